// File: rtl/step_gen.sv
// step_gen: integrates signed fixed-point speed into a position accumulator and
// emits timed step/dir pulses so the emitted step count tracks its integer part.
module step_gen #(
  parameter int PULSE_WIDTH = 50,
  parameter int DIR_SETUP   = 50,
  parameter int FRAC_BITS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_tick,
  input  logic        enable,
  input  logic [63:0] speed,
  input  logic        set_pos,
  input  logic [31:0] pos_in,
  input  logic        clear_err,
  output logic        step,
  output logic        dir,
  output logic [31:0] position,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_PULSE_HI, S_PULSE_LO} state_t;
  localparam int CMAX = PULSE_WIDTH > DIR_SETUP ? PULSE_WIDTH : DIR_SETUP;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PW_M1 = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] DS_M1 = CW'(DIR_SETUP - 1);
  // largest magnitude that moves the integer part by at most one per tick
  localparam logic signed [63:0] SAT = (64'sd1 <<< FRAC_BITS) - 64'sd1;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [63:0]   r_acc, w_inc, w_load;
  logic [31:0]   r_pos, w_pos, w_target, w_diff, w_pstep;
  logic          r_step, w_step, r_dir, w_dir, r_ovr;
  logic          w_hi, w_lo, w_nz, w_match, w_big, w_lag, w_int;

  assign w_hi     = $signed(speed) > SAT;
  assign w_lo     = $signed(speed) < -SAT;
  assign w_inc    = w_hi ? 64'(SAT) : w_lo ? 64'(-SAT) : speed;
  assign w_int    = step_tick && enable;
  assign w_load   = {{32{pos_in[31]}}, pos_in} << FRAC_BITS;
  assign w_target = r_acc[FRAC_BITS +: 32];
  assign w_diff   = w_target - r_pos;
  assign w_nz     = |w_diff;
  assign w_match  = w_diff[31] != r_dir;
  assign w_big    = $signed(w_diff) > 32'sd1 || $signed(w_diff) < -32'sd1;
  assign w_pstep  = r_dir ? r_pos + 32'd1 : r_pos - 32'd1;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_step  = r_step;
    w_dir   = r_dir;
    w_pos   = r_pos;
    w_lag   = 1'b0;
    case (r_state)
      S_IDLE: if (w_nz) begin
        w_lag = w_big;
        if (w_match) begin
          w_state = S_PULSE_HI;
          w_step  = 1'b1;
          w_pos   = w_pstep;
          w_cnt   = PW_M1;
        end else begin
          w_state = S_DIR_SETUP;
          w_dir   = ~r_dir;
          w_cnt   = DS_M1;
        end
      end
      S_DIR_SETUP: if (!w_nz) w_state = S_IDLE;
        else if (|r_cnt) w_cnt = r_cnt - 1'b1;
        else if (w_match) begin
          w_state = S_PULSE_HI;
          w_step  = 1'b1;
          w_pos   = w_pstep;
          w_cnt   = PW_M1;
        end else w_state = S_IDLE;
      S_PULSE_HI: if (|r_cnt) w_cnt = r_cnt - 1'b1;
        else begin
          w_state = S_PULSE_LO;
          w_step  = 1'b0;
          w_cnt   = PW_M1;
        end
      default: if (|r_cnt) w_cnt = r_cnt - 1'b1;
        else w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_pos   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_ovr   <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (set_pos) begin
      r_acc   <= w_load;
      r_pos   <= pos_in;
      r_step  <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ovr   <= r_ovr & ~clear_err;
    end else begin
      if (w_int) r_acc <= r_acc + w_inc;
      r_pos   <= w_pos;
      r_step  <= w_step;
      r_dir   <= w_dir;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_ovr   <= (w_int && (w_hi || w_lo)) || w_lag || (r_ovr && !clear_err);
    end
  end

  assign step     = r_step;
  assign dir      = r_dir;
  assign position = r_pos;
  assign busy     = r_state != S_IDLE;
  assign overrun  = r_ovr;
endmodule
